// File: rtl/temp_uart_formatter_if.sv
// Handshake bundle between a temperature source, the ASCII formatter and a UART transmitter.
// The formatter takes the slave side; whoever feeds samples and done ticks takes the master side.
interface temp_uart_formatter_if;
    logic        temp_valid;
    logic [11:0] temp_data;
    logic        tx_done_tick;
    logic [7:0]  data_byte;
    logic        tx_start;
    logic        busy;
    logic        overrun;

    modport master (
        output temp_valid, temp_data, tx_done_tick,
        input  data_byte, tx_start, busy, overrun
    );

    modport slave (
        input  temp_valid, temp_data, tx_done_tick,
        output data_byte, tx_start, busy, overrun
    );
endinterface

// File: rtl/temp_uart_formatter.sv
// Turns a 12-bit signed temperature sample (1/16 degC) into an ASCII frame such as "+025.0\r\n"
// and hands it byte by byte to a UART transmitter using an active-low start / done-tick handshake.
module temp_uart_formatter #(
    parameter bit SEND_LF = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    temp_uart_formatter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONVERT, SEND, WAIT} state_t;

    localparam logic [2:0] LAST_IDX = SEND_LF ? 3'd7 : 3'd6;

    state_t      state_q, state_d;
    logic        sign_q;
    logic [3:0]  frac_q;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  data_byte_q;
    logic        tx_start_q;
    logic        busy_q;
    logic        overrun_q;

    logic        capture, shift, load_byte, next_byte, finish;
    logic [11:0] mag;
    logic [7:0]  tenths;
    logic [7:0]  frame_byte;

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        for (int k = 0; k < 3; k++) begin
            r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        end
        return r;
    endfunction

    // 0x800 negates to itself, which read as unsigned is exactly the 2048 we want.
    assign mag    = bus.temp_data[11] ? (~bus.temp_data + 12'd1) : bus.temp_data;
    assign tenths = ({4'b0000, frac_q} * 8'd10) >> 4;

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = sign_q ? 8'h2D : 8'h2B;
            3'd1:    frame_byte = {4'h3, bcd_q[11:8]};
            3'd2:    frame_byte = {4'h3, bcd_q[7:4]};
            3'd3:    frame_byte = {4'h3, bcd_q[3:0]};
            3'd4:    frame_byte = 8'h2E;
            3'd5:    frame_byte = 8'h30 + tenths;
            3'd6:    frame_byte = 8'h0D;
            default: frame_byte = 8'h0A;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        shift     = 1'b0;
        load_byte = 1'b0;
        next_byte = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.temp_valid) begin
                    capture = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                shift = 1'b1;
                if (bit_cnt_q == 3'd7) state_d = SEND;
            end
            SEND: begin
                load_byte = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        next_byte = 1'b1;
                        state_d   = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q    <= 1'b0;
            frac_q    <= 4'h0;
            bin_q     <= 8'h00;
            bcd_q     <= 12'h000;
            bit_cnt_q <= 3'd0;
            idx_q     <= 3'd0;
        end else if (capture) begin
            sign_q    <= bus.temp_data[11];
            frac_q    <= mag[3:0];
            bin_q     <= mag[11:4];
            bcd_q     <= 12'h000;
            bit_cnt_q <= 3'd0;
            idx_q     <= 3'd0;
        end else if (shift) begin
            {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
            bit_cnt_q      <= bit_cnt_q + 3'd1;
        end else if (next_byte) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    // Registered outputs: the byte chosen in SEND reaches the transmitter together with the start strobe
    // on the following cycle and stays put until the next SEND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_byte_q <= 8'h00;
            tx_start_q  <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_start_q <= ~load_byte;
            if (load_byte) data_byte_q <= frame_byte;
            if (capture)     busy_q <= 1'b1;
            else if (finish) busy_q <= 1'b0;
            overrun_q <= bus.temp_valid & busy_q;
        end
    end

    assign bus.data_byte = data_byte_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_temp_uart_formatter.sv
// Directed bench for temp_uart_formatter: a small UART-side responder walks each frame byte by byte
// against hand-written ASCII strings. Cycle 0 is the cycle temp_valid is presented.
module tb_temp_uart_formatter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    temp_uart_formatter_if bus1 ();
    temp_uart_formatter_if bus0 ();

    temp_uart_formatter #(.SEND_LF(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    temp_uart_formatter #(.SEND_LF(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    int ovr1 = 0, ovr0 = 0, starts1 = 0, starts0 = 0;
    int run1 = 0, run0 = 0, max_run1 = 0, max_run0 = 0;

    always @(negedge clk) begin
        if (bus1.overrun === 1'b1) ovr1 <= ovr1 + 1;
        if (bus0.overrun === 1'b1) ovr0 <= ovr0 + 1;
        if (bus1.tx_start === 1'b0) begin
            starts1 <= starts1 + 1;
            run1    <= run1 + 1;
            if (run1 + 1 > max_run1) max_run1 <= run1 + 1;
        end else begin
            run1 <= 0;
        end
        if (bus0.tx_start === 1'b0) begin
            starts0 <= starts0 + 1;
            run0    <= run0 + 1;
            if (run0 + 1 > max_run0) max_run0 <= run0 + 1;
        end else begin
            run0 <= 0;
        end
    end

    function automatic logic get_tx_start(input bit u);
        return u ? bus1.tx_start : bus0.tx_start;
    endfunction

    function automatic logic get_busy(input bit u);
        return u ? bus1.busy : bus0.busy;
    endfunction

    function automatic logic [7:0] get_data(input bit u);
        return u ? bus1.data_byte : bus0.data_byte;
    endfunction

    task automatic drive(input bit u, input logic v, input logic [11:0] d, input logic done);
        if (u) begin
            bus1.temp_valid = v; bus1.temp_data = d; bus1.tx_done_tick = done;
        end else begin
            bus0.temp_valid = v; bus0.temp_data = d; bus0.tx_done_tick = done;
        end
    endtask

    function automatic logic [7:0] exp_byte(input string s, input int i);
        if (i < 6)  return s[i];
        if (i == 6) return 8'h0D;
        return 8'h0A;
    endfunction

    // Sends one sample and answers each start strobe with a done tick 'gap' cycles later.
    task automatic run_frame(input bit u, input logic [11:0] d, input string s, input int nbytes,
                             input int gap, input int ovr_byte, input bit ovr_last,
                             input bit spurious, input int abort_at);
        int cyc, t, ov_start, st_start, exp_ovr;
        logic [7:0] eb;
        ov_start = u ? ovr1 : ovr0;
        st_start = u ? starts1 : starts0;
        if (spurious) begin
            @(negedge clk); drive(u, 1'b0, 12'h000, 1'b1);
        end
        @(negedge clk); drive(u, 1'b1, d, 1'b0); cyc = 0;
        @(negedge clk); drive(u, 1'b0, 12'h000, 1'b0); cyc = 1;
        check($sformatf("%s busy_set", s), get_busy(u), 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            eb = exp_byte(s, i);
            t  = 0;
            while (get_tx_start(u) !== 1'b0 && t < 64) begin
                drive(u, 1'b0, 12'h000, spurious && i == 0 && cyc == 3);
                @(negedge clk); cyc++; t++;
            end
            drive(u, 1'b0, 12'h000, 1'b0);
            check($sformatf("%s b%0d start_low", s, i), get_tx_start(u), 1'b0);
            if (i == 0) check($sformatf("%s first_start_cycle", s), cyc, 10);
            check($sformatf("%s b%0d byte", s, i), get_data(u), eb);
            if (i == abort_at) return;
            @(negedge clk); cyc++;
            check($sformatf("%s b%0d single_low", s, i), get_tx_start(u), 1'b1);
            for (int k = 1; k < gap; k++) begin
                drive(u, (i == ovr_byte && k == 1), 12'h555, 1'b0);
                @(negedge clk); cyc++;
            end
            check($sformatf("%s b%0d held", s, i), {get_tx_start(u), get_data(u)}, {1'b1, eb});
            drive(u, ovr_last && i == nbytes - 1, 12'h555, 1'b1);
            @(negedge clk); cyc++;
            drive(u, 1'b0, 12'h000, 1'b0);
            if (i == nbytes - 1) check($sformatf("%s busy_clear", s), get_busy(u), 1'b0);
        end
        repeat (6) @(negedge clk);
        exp_ovr = (ovr_byte >= 0 ? 1 : 0) + (ovr_last ? 1 : 0);
        check($sformatf("%s overrun_count", s), (u ? ovr1 : ovr0) - ov_start, exp_ovr);
        check($sformatf("%s start_count", s), (u ? starts1 : starts0) - st_start, nbytes);
        check($sformatf("%s idle_after", s), get_busy(u), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        drive(1'b1, 1'b0, 12'h000, 1'b0);
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        check("rst tx_start", {bus1.tx_start, bus0.tx_start}, 2'b11);
        check("rst busy", {bus1.busy, bus0.busy}, 2'b00);
        check("rst data_byte", bus1.data_byte, 8'h00);
        check("rst overrun", {bus1.overrun, bus0.overrun}, 2'b00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(1'b1, 12'h191, "+025.0", 8, 3, -1, 1'b0, 1'b1, -1);
        run_frame(1'b1, 12'hF5E, "-010.1", 8, 2, -1, 1'b0, 1'b0, -1);
        run_frame(1'b1, 12'h7D0, "+125.0", 8, 2, -1, 1'b0, 1'b0, -1);
        run_frame(1'b1, 12'h800, "-128.0", 8, 2, -1, 1'b0, 1'b0, -1);
        run_frame(1'b1, 12'hFFF, "-000.0", 8, 2, -1, 1'b0, 1'b0, -1);
        run_frame(1'b1, 12'h0FF, "+015.9", 8, 2, -1, 1'b0, 1'b0, -1);
        run_frame(1'b1, 12'h191, "+025.0", 8, 3,  3, 1'b1, 1'b0, -1);
        run_frame(1'b1, 12'h320, "+050.0", 8, 40, -1, 1'b0, 1'b0, -1);
        run_frame(1'b0, 12'h000, "+000.0", 7, 3, -1, 1'b0, 1'b0, -1);

        // Abort during byte 4: the strobe is low right now, so the async reset must lift it at once.
        run_frame(1'b1, 12'h191, "+025.0", 8, 3, -1, 1'b0, 1'b0, 4);
        reset = 1'b0;
        #1;
        check("abort tx_start_async", bus1.tx_start, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort c%0d tx_start", k), bus1.tx_start, 1'b1);
            check($sformatf("abort c%0d busy", k), bus1.busy, 1'b0);
        end
        check("abort data_byte", bus1.data_byte, 8'h00);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort no_resume", {bus1.tx_start, bus1.busy}, 2'b10);
        run_frame(1'b1, 12'h191, "+025.0", 8, 3, -1, 1'b0, 1'b0, -1);

        check("max_low_run dut1", max_run1, 1);
        check("max_low_run dut0", max_run0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/temp_uart_formatter.md
TEMP_UART_FORMATTER -- requirements
Module: temp_uart_formatter

Interface
REQ-001 Parameter: SEND_LF, default 1, meaning 1 = frame ends CR+LF (8 bytes), 0 = frame ends CR only (7 bytes).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release synchronous to clk.
REQ-004 temp_valid  input  1  one-cycle strobe; temp_data valid this cycle.
REQ-005 temp_data  input  12  signed two's complement temperature, LSB = 1/16 degC.
REQ-006 tx_done_tick  input  1  one-cycle pulse from UART transmitter, current byte finished.
REQ-007 data_byte  output  8  ASCII byte presented to UART transmitter.
REQ-008 tx_start  output  1  active-low start request to UART transmitter; idles high.
REQ-009 busy  output  1  high from capture until last byte's tx_done_tick.
REQ-010 overrun  output  1  one-cycle pulse when temp_valid arrives while busy.

Function
REQ-011 Frame SHALL be: sign, hundreds, tens, units, '.', tenths, CR (0x0D), then LF (0x0A) when SEND_LF=1.
REQ-012 Sign SHALL be '+' (0x2B) when temp_data[11]=0, '-' (0x2D) when 1, including values that print as 000.0.
REQ-013 Magnitude SHALL be |temp_data| as 12-bit unsigned (0x800 -> 2048); integer part = magnitude[11:4] (0..128), fraction = magnitude[3:0].
REQ-014 Tenths digit SHALL be (fraction*10)>>4, truncated, range 0..9.
REQ-015 Integer digits SHALL always be three, leading zeros printed; digit byte = 0x30 + BCD value.
REQ-016 States SHALL be IDLE, CONVERT, SEND, WAIT.
REQ-017 IDLE: temp_valid=1 captures temp_data, sets busy, goes to CONVERT; otherwise stay.
REQ-018 CONVERT: sequential binary-to-BCD of the 8-bit integer part, one shift iteration per clk, exactly 8 cycles, then SEND with byte index 0.
REQ-019 SEND: lasts exactly one cycle; tx_start=0, data_byte=frame[index]; next state WAIT.
REQ-020 First tx_start low cycle SHALL be the 10th clk cycle after the capture edge (capture edge = cycle 0).
REQ-021 WAIT: tx_start=1, data_byte held unchanged; on tx_done_tick, if index is last byte go to IDLE and clear busy in same edge, else increment index and go to SEND.
REQ-022 tx_start SHALL never be low for more than one consecutive cycle, and SHALL be low only in SEND.
REQ-023 data_byte SHALL be stable from SEND cycle through the tx_done_tick cycle of that byte.
REQ-024 tx_done_tick outside WAIT SHALL be ignored.
REQ-025 temp_valid while busy=1 SHALL be discarded (frame in progress unaffected) and pulse overrun for one cycle.
REQ-026 temp_valid coincident with the final tx_done_tick SHALL be discarded with overrun pulse (busy still 1 that cycle).
REQ-027 No timeout: WAIT held indefinitely absent tx_done_tick.

Reset
REQ-028 On reset low: state=IDLE, busy=0, tx_start=1, data_byte=0x00, overrun=0, byte index=0, capture and BCD registers=0.
REQ-029 Reset asserted mid-frame SHALL abort frame with no further tx_start pulses; first temp_valid after release starts a fresh full frame.

Verification
REQ-030 temp_data=0x191 (25.0625) -> bytes 2B 30 32 35 2E 30 0D 0A, one tx_start low per byte, first at cycle 10.
REQ-031 temp_data=0xF5E (-10.125) -> 2D 30 31 30 2E 31 0D 0A.
REQ-032 temp_data=0x7D0 (125.0) -> "+125.0\r\n"; temp_data=0x800 -> "-128.0\r\n"; temp_data=0xFFF -> "-000.0\r\n".
REQ-033 SEND_LF=0, temp_data=0x000 -> 2B 30 30 30 2E 30 0D only, busy falls on 7th tx_done_tick.
REQ-034 temp_valid pulsed during byte 3 WAIT and again coincident with last tx_done_tick -> two overrun pulses, original frame intact, busy=0 afterward.
REQ-035 Reset low during WAIT of byte 4, released, then temp_valid 0x191 -> tx_start high throughout reset, then full 8-byte frame from byte 0.
